// File: rtl/barrel_shift_pkg.sv
// Shared constants, operand types and FSM state encoding for barrel_shift_arbiter.
// Latency: n/a (types only). Backpressure: n/a.
// Optional feature macro: BARREL_SHIFT_ARBITER_RR_EN (see barrel_shift_arbiter).
package barrel_shift_pkg;

   localparam int N = 8;
   localparam int M = $clog2(N);

   typedef logic [N-1:0] data_t;
   typedef logic [M-1:0] amt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      RESP  = 2'd2
   } state_t;

endpackage

// File: rtl/modified_barrel_shift.sv
// Combinational circular rotate: LR=1 rotates left, LR=0 rotates right, no bit loss.
// Latency: 0 cycles (pure combinational). Backpressure: none.
module modified_barrel_shift #(
   parameter int N = 8,
   parameter int M = 3
) (
   input  logic [N-1:0] In,
   input  logic [M-1:0] Num,
   input  logic         LR,
   output logic [N-1:0] Out
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] rot_l;
   logic [2*N-1:0] rot_r;

   // Shifting a doubled copy keeps the wrapped bits in the window we slice out.
   always_comb begin
      dbl   = {In, In};
      rot_l = dbl << Num;
      rot_r = dbl >> Num;
      Out   = LR ? rot_l[2*N-1:N] : rot_r[N-1:0];
   end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Two requesters share one rotator; grant in IDLE, result valid two cycles after accept.
// Res_Valid holds Res_Out/Res_Id until Res_Ready; no grants while a result is in flight.
// BARREL_SHIFT_ARBITER_RR_EN selects round-robin tie-break; otherwise requester 0 always wins.
module barrel_shift_arbiter #(
   parameter int N = barrel_shift_pkg::N,
   parameter int M = barrel_shift_pkg::M
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         Req0_Valid,
   output logic         Req0_Ready,
   input  logic [N-1:0] Req0_In,
   input  logic [M-1:0] Req0_Num,
   input  logic         Req0_LR,
   input  logic         Req1_Valid,
   output logic         Req1_Ready,
   input  logic [N-1:0] Req1_In,
   input  logic [M-1:0] Req1_Num,
   input  logic         Req1_LR,
   output logic         Res_Valid,
   input  logic         Res_Ready,
   output logic [N-1:0] Res_Out,
   output logic         Res_Id
);

   import barrel_shift_pkg::*;

   state_t       state_q;
   logic [N-1:0] op_in_q;
   logic [M-1:0] op_num_q;
   logic         op_lr_q;
   logic         op_id_q;
   logic [N-1:0] res_out_q;
   logic         res_id_q;
   logic         res_vld_q;

   logic [N-1:0] op_in_d;
   logic [M-1:0] op_num_d;
   logic         op_lr_d;
   logic [N-1:0] shift_out;
   logic         prio0;
   logic         gnt0;
   logic         gnt1;

`ifdef BARREL_SHIFT_ARBITER_RR_EN
   logic last_q;
   // last_q holds the id of the previous grant; requester 0 leads after a grant to 1.
   assign prio0 = last_q;
`else
   assign prio0 = 1'b1;
`endif

   always_comb begin
      gnt0     = (state_q == IDLE) && !Rst && Req0_Valid && (prio0 || !Req1_Valid);
      gnt1     = (state_q == IDLE) && !Rst && Req1_Valid && !gnt0;
      op_in_d  = gnt1 ? Req1_In  : Req0_In;
      op_num_d = gnt1 ? Req1_Num : Req0_Num;
      op_lr_d  = gnt1 ? Req1_LR  : Req0_LR;
   end

   assign Req0_Ready = gnt0;
   assign Req1_Ready = gnt1;
   assign Res_Valid  = res_vld_q;
   assign Res_Out    = res_out_q;
   assign Res_Id     = res_id_q;

   modified_barrel_shift #(.N(N), .M(M)) u_shift (
      .In  (op_in_q),
      .Num (op_num_q),
      .LR  (op_lr_q),
      .Out (shift_out)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= IDLE;
         op_in_q   <= '0;
         op_num_q  <= '0;
         op_lr_q   <= 1'b0;
         op_id_q   <= 1'b0;
         res_out_q <= '0;
         res_id_q  <= 1'b0;
         res_vld_q <= 1'b0;
`ifdef BARREL_SHIFT_ARBITER_RR_EN
         last_q    <= 1'b1;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  op_in_q  <= op_in_d;
                  op_num_q <= op_num_d;
                  op_lr_q  <= op_lr_d;
                  op_id_q  <= gnt1;
                  state_q  <= SHIFT;
`ifdef BARREL_SHIFT_ARBITER_RR_EN
                  last_q   <= gnt1;
`endif
               end
            end
            SHIFT: begin
               res_out_q <= shift_out;
               res_id_q  <= op_id_q;
               res_vld_q <= 1'b1;
               state_q   <= RESP;
            end
            RESP: begin
               if (Res_Ready) begin
                  res_vld_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed and random bench for barrel_shift_arbiter; expected grant order follows
// BARREL_SHIFT_ARBITER_RR_EN when defined at compile time.
module tb_barrel_shift_arbiter;

   localparam int N = 8;
   localparam int M = 3;

   logic         Clk = 1'b0;
   logic         Rst;
   logic         Req0_Valid, Req1_Valid;
   logic         Req0_Ready, Req1_Ready;
   logic [N-1:0] Req0_In, Req1_In;
   logic [M-1:0] Req0_Num, Req1_Num;
   logic         Req0_LR, Req1_LR;
   logic         Res_Valid, Res_Ready;
   logic [N-1:0] Res_Out;
   logic         Res_Id;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   barrel_shift_arbiter #(.N(N), .M(M)) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .Req0_Valid (Req0_Valid),
      .Req0_Ready (Req0_Ready),
      .Req0_In    (Req0_In),
      .Req0_Num   (Req0_Num),
      .Req0_LR    (Req0_LR),
      .Req1_Valid (Req1_Valid),
      .Req1_Ready (Req1_Ready),
      .Req1_In    (Req1_In),
      .Req1_Num   (Req1_Num),
      .Req1_LR    (Req1_LR),
      .Res_Valid  (Res_Valid),
      .Res_Ready  (Res_Ready),
      .Res_Out    (Res_Out),
      .Res_Id     (Res_Id)
   );

   // {id, in, num, lr, expected}
   logic [20:0] vec [8] = '{
      {1'b0, 8'hA5, 3'd1, 1'b0, 8'hD2},
      {1'b1, 8'h81, 3'd3, 1'b1, 8'h0C},
      {1'b1, 8'h81, 3'd0, 1'b1, 8'h81},
      {1'b1, 8'h81, 3'd0, 1'b0, 8'h81},
      {1'b0, 8'h01, 3'd7, 1'b1, 8'h80},
      {1'b0, 8'h80, 3'd7, 1'b0, 8'h01},
      {1'b1, 8'h3C, 3'd4, 1'b0, 8'hC3},
      {1'b0, 8'h96, 3'd5, 1'b1, 8'hD2}
   };

   function automatic logic [7:0] rot_ref(input logic [7:0] x, input int n, input logic lr);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (lr) r[(i + n) % 8] = x[i];
         else    r[i] = x[(i + n) % 8];
      end
      return r;
   endfunction

   task automatic drain(input int cycles);
      Req0_Valid = 1'b0;
      Req1_Valid = 1'b0;
      Res_Ready  = 1'b1;
      repeat (cycles) @(posedge Clk);
      #1;
   endtask

   // Issues one request and waits for its result; entered and left at posedge+1.
   task automatic do_op(input logic id, input logic [7:0] din, input logic [2:0] num,
                        input logic lr, output logic gnt_ok, output int lat,
                        output logic [7:0] rout, output logic rid);
      gnt_ok = 1'b0;
      lat    = -1;
      rout   = '0;
      rid    = 1'b0;
      Res_Ready = 1'b1;
      if (id) begin Req1_Valid = 1'b1; Req1_In = din; Req1_Num = num; Req1_LR = lr; end
      else    begin Req0_Valid = 1'b1; Req0_In = din; Req0_Num = num; Req0_LR = lr; end
      for (int k = 0; k < 10 && !gnt_ok; k++) begin
         @(negedge Clk);
         if (id ? Req1_Ready : Req0_Ready) gnt_ok = 1'b1;
         else begin @(posedge Clk); #1; end
      end
      for (int k = 1; k <= 10 && lat < 0 && gnt_ok; k++) begin
         @(posedge Clk); #1;
         Req0_Valid = 1'b0;
         Req1_Valid = 1'b0;
         @(negedge Clk);
         if (Res_Valid) begin lat = k; rout = Res_Out; rid = Res_Id; end
      end
      Req0_Valid = 1'b0;
      Req1_Valid = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      Req0_Valid = 1'b1; Req1_Valid = 1'b1;
      Req0_In = 8'h11; Req1_In = 8'h22;
      Req0_Num = 3'd1; Req1_Num = 3'd2; Req0_LR = 1'b0; Req1_LR = 1'b1;
      Res_Ready = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      checks++; if (Req0_Ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %b want 0", Req0_Ready); end
      checks++; if (Req1_Ready !== 1'b0) begin errors++; $display("FAIL rst_ready1 got %b want 0", Req1_Ready); end
      checks++; if (Res_Valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b want 0", Res_Valid); end
      checks++; if (Res_Out !== 8'h00) begin errors++; $display("FAIL rst_res_out got %h want 00", Res_Out); end
      checks++; if (Res_Id !== 1'b0) begin errors++; $display("FAIL rst_res_id got %b want 0", Res_Id); end
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(negedge Clk);
      checks++;
      if (Req0_Ready !== 1'b1 || Req1_Ready !== 1'b0) begin
         errors++; $display("FAIL first_tie got r0=%b r1=%b want r0=1 r1=0", Req0_Ready, Req1_Ready);
      end
      @(posedge Clk); #1;
      drain(4);
   endtask

   task automatic test_vectors();
      logic g; int lat; logic [7:0] ro; logic ri;
      for (int i = 0; i < 8; i++) begin
         do_op(vec[i][20], vec[i][19:12], vec[i][11:9], vec[i][8], g, lat, ro, ri);
         checks++; if (g !== 1'b1) begin errors++; $display("FAIL vec%0d_grant got %b want 1", i, g); end
         checks++; if (lat !== 2) begin errors++; $display("FAIL vec%0d_latency got %0d want 2", i, lat); end
         checks++; if (ro !== vec[i][7:0]) begin errors++; $display("FAIL vec%0d_out got %h want %h", i, ro, vec[i][7:0]); end
         checks++; if (ri !== vec[i][20]) begin errors++; $display("FAIL vec%0d_id got %b want %b", i, ri, vec[i][20]); end
      end
   endtask

   task automatic test_arbitration();
      int exp_id [4];
      int got_id [4];
      int got_cyc [4];
      int n = 0;
      logic both = 1'b0;
`ifdef BARREL_SHIFT_ARBITER_RR_EN
      exp_id = '{0, 1, 0, 1};
`else
      exp_id = '{0, 0, 0, 0};
`endif
      Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      Res_Ready = 1'b1;
      Req0_Valid = 1'b1; Req0_In = 8'hF0; Req0_Num = 3'd2; Req0_LR = 1'b0;
      Req1_Valid = 1'b1; Req1_In = 8'h0F; Req1_Num = 3'd2; Req1_LR = 1'b1;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge Clk);
         if (Req0_Ready && Req1_Ready) both = 1'b1;
         if (Req0_Ready || Req1_Ready) begin
            got_id[n] = Req1_Ready ? 1 : 0;
            got_cyc[n] = c;
            n++;
         end
         @(posedge Clk); #1;
      end
      drain(4);
      checks++; if (n !== 4) begin errors++; $display("FAIL arb_grant_count got %0d want 4", n); end
      checks++; if (both !== 1'b0) begin errors++; $display("FAIL arb_one_hot got both=1 want 0"); end
      for (int i = 0; i < 4 && i < n; i++) begin
         checks++;
         if (got_id[i] !== exp_id[i]) begin errors++; $display("FAIL arb_order%0d got %0d want %0d", i, got_id[i], exp_id[i]); end
         if (i > 0) begin
            checks++;
            if (got_cyc[i] - got_cyc[i-1] < 3) begin
               errors++; $display("FAIL arb_spacing%0d got %0d want >=3", i, got_cyc[i] - got_cyc[i-1]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      Res_Ready = 1'b0;
      Req0_Valid = 1'b1; Req0_In = 8'h5A; Req0_Num = 3'd2; Req0_LR = 1'b1;
      Req1_Valid = 1'b1; Req1_In = 8'h0F; Req1_Num = 3'd1; Req1_LR = 1'b0;
      @(negedge Clk);
      checks++;
      if (Req0_Ready !== 1'b1 || Req1_Ready !== 1'b0) begin
         errors++; $display("FAIL bp_grant got r0=%b r1=%b want r0=1 r1=0", Req0_Ready, Req1_Ready);
      end
      @(posedge Clk); #1;
      Req0_Valid = 1'b0;
      @(negedge Clk);
      checks++;
      if (Req1_Ready !== 1'b0 || Res_Valid !== 1'b0) begin
         errors++; $display("FAIL bp_shift got r1=%b vld=%b want r1=0 vld=0", Req1_Ready, Res_Valid);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge Clk); #1;
         @(negedge Clk);
         checks++;
         if (Res_Valid !== 1'b1 || Res_Out !== 8'h69 || Res_Id !== 1'b0 || Req0_Ready !== 1'b0 || Req1_Ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d got vld=%b out=%h id=%b r0=%b r1=%b want vld=1 out=69 id=0 r0=0 r1=0",
                     i, Res_Valid, Res_Out, Res_Id, Req0_Ready, Req1_Ready);
         end
      end
      @(posedge Clk); #1;
      Res_Ready = 1'b1;
      @(negedge Clk);
      checks++;
      if (Res_Valid !== 1'b1 || Req1_Ready !== 1'b0) begin
         errors++; $display("FAIL bp_accept got vld=%b r1=%b want vld=1 r1=0", Res_Valid, Req1_Ready);
      end
      @(posedge Clk); #1;
      @(negedge Clk);
      checks++;
      if (Req1_Ready !== 1'b1 || Res_Valid !== 1'b0) begin
         errors++; $display("FAIL bp_regrant got r1=%b vld=%b want r1=1 vld=0", Req1_Ready, Res_Valid);
      end
      @(posedge Clk); #1;
      drain(4);
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      Res_Ready = 1'b1;
      Req0_Valid = 1'b1; Req0_In = 8'hC3; Req0_Num = 3'd3; Req0_LR = 1'b0;
      @(negedge Clk);
      checks++; if (Req0_Ready !== 1'b1) begin errors++; $display("FAIL rmid_grant got %b want 1", Req0_Ready); end
      @(posedge Clk); #1;
      Req0_Valid = 1'b0;
      Rst = 1'b1;
      @(negedge Clk);
      checks++; if (Res_Valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", Res_Valid); end
      @(posedge Clk); #1;
      Rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         if (Res_Valid !== 1'b0) seen = 1'b1;
         @(posedge Clk); #1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_discard got stray Res_Valid want none"); end
      Req0_Valid = 1'b1; Req1_Valid = 1'b1;
      @(negedge Clk);
      checks++;
      if (Req0_Ready !== 1'b1 || Req1_Ready !== 1'b0) begin
         errors++; $display("FAIL rmid_tie got r0=%b r1=%b want r0=1 r1=0", Req0_Ready, Req1_Ready);
      end
      @(posedge Clk); #1;
      drain(4);
   endtask

   task automatic test_stress();
      logic       pv [2];
      logic [7:0] pin [2];
      logic [2:0] pnum [2];
      logic       plr [2];
      logic       clr [2];
      logic [8:0] q [$];
      logic [8:0] exp;
      int grants = 0, done = 0, cyc = 0;
      for (int r = 0; r < 2; r++) begin pv[r] = 1'b0; clr[r] = 1'b0; pin[r] = '0; pnum[r] = '0; plr[r] = 1'b0; end
      while ((grants < 1000 || done < grants) && cyc < 20000) begin
         for (int r = 0; r < 2; r++) begin
            if (clr[r] || grants >= 1000) pv[r] = 1'b0;
            else if (!pv[r]) begin
               if ($urandom_range(1, 0) == 1) begin
                  pv[r] = 1'b1; pin[r] = 8'($urandom); pnum[r] = 3'($urandom_range(7, 0)); plr[r] = 1'($urandom_range(1, 0));
               end
            end else if ($urandom_range(15, 0) == 0) pv[r] = 1'b0;
            clr[r] = 1'b0;
         end
         Res_Ready = 1'($urandom_range(1, 0));
         Req0_Valid = pv[0]; Req0_In = pin[0]; Req0_Num = pnum[0]; Req0_LR = plr[0];
         Req1_Valid = pv[1]; Req1_In = pin[1]; Req1_Num = pnum[1]; Req1_LR = plr[1];
         @(negedge Clk);
         if (Req0_Ready || Req1_Ready) begin
            checks++;
            if (Req0_Ready && Req1_Ready) begin errors++; $display("FAIL stress_one_hot got both Ready at cycle %0d", cyc); end
            if (Req0_Ready) begin q.push_back({1'b0, rot_ref(pin[0], int'(pnum[0]), plr[0])}); clr[0] = 1'b1; end
            else            begin q.push_back({1'b1, rot_ref(pin[1], int'(pnum[1]), plr[1])}); clr[1] = 1'b1; end
            grants++;
         end
         if (Res_Valid && Res_Ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL stress_dup got result id=%b out=%h want none pending", Res_Id, Res_Out);
            end else begin
               exp = q.pop_front();
               if ({Res_Id, Res_Out} !== exp) begin
                  errors++; $display("FAIL stress_result%0d got id=%b out=%h want id=%b out=%h", done, Res_Id, Res_Out, exp[8], exp[7:0]);
               end
            end
            done++;
         end
         @(posedge Clk); #1;
         cyc++;
      end
      drain(4);
      checks++; if (cyc >= 20000) begin errors++; $display("FAIL stress_timeout got %0d cycles want <20000", cyc); end
      checks++; if (grants !== 1000) begin errors++; $display("FAIL stress_grants got %0d want 1000", grants); end
      checks++; if (done !== grants) begin errors++; $display("FAIL stress_results got %0d want %0d", done, grants); end
      checks++; if (q.size() !== 0) begin errors++; $display("FAIL stress_lost got %0d pending want 0", q.size()); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_vectors();
      test_arbitration();
      test_backpressure();
      test_reset_mid();
      test_stress();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
